board_engine: RTL and testbench

BOARD_ENGINE -- requirements
Module: board_engine

---
 rtl/battle_pkg.sv | 26 ++
 rtl/board_bank.sv | 57 +++++
 rtl/board_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_board_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared encodings for the board engine: cell values, shot results and FSM states.
// Also holds the coordinate range check used by the storage and control logic.
package battle_pkg;

   localparam logic [1:0] CELL_WATER = 2'b00;
   localparam logic [1:0] CELL_SHIP  = 2'b01;
   localparam logic [1:0] CELL_MISS  = 2'b10;
   localparam logic [1:0] CELL_HIT   = 2'b11;

   localparam logic [1:0] RES_REJECT = 2'b00;
   localparam logic [1:0] RES_MISS   = 2'b10;
   localparam logic [1:0] RES_HIT    = 2'b11;

   typedef enum logic [2:0] {
      ST_SETUP     = 3'd0,
      ST_AIM       = 3'd1,
      ST_RESOLVE   = 3'd2,
      ST_REPORT    = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   function automatic logic coord_ok(input int row, input int col, input int size);
      return (row < size) && (col < size);
   endfunction

endpackage

// File: rtl/board_bank.sv
// One player's board: a square array of 2-bit cells with a write port, an
// internal read port for the controller and a display read port.
module board_bank
   import battle_pkg::*;
#(
   parameter int BOARD_SIZE = 10,
   localparam int IDX_W = $clog2(BOARD_SIZE)
) (
   input  logic             clock50,
   input  logic             reset,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_row,
   input  logic [IDX_W-1:0] wr_col,
   input  logic [1:0]       wr_data,
   input  logic [IDX_W-1:0] rd_row,
   input  logic [IDX_W-1:0] rd_col,
   output logic [1:0]       rd_data,
   input  logic [IDX_W-1:0] disp_row,
   input  logic [IDX_W-1:0] disp_col,
   output logic [1:0]       disp_data
);

   logic [1:0] cells_r [BOARD_SIZE][BOARD_SIZE];

   // Cell storage: cleared by reset or clear, otherwise written only in range.
   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < BOARD_SIZE; r++)
            for (int c = 0; c < BOARD_SIZE; c++)
               cells_r[r][c] <= CELL_WATER;
      end else if (clear) begin
         for (int r = 0; r < BOARD_SIZE; r++)
            for (int c = 0; c < BOARD_SIZE; c++)
               cells_r[r][c] <= CELL_WATER;
      end else if (wr_en && coord_ok(int'(wr_row), int'(wr_col), BOARD_SIZE)) begin
         cells_r[wr_row][wr_col] <= wr_data;
      end
   end

   // Read ports: out-of-range coordinates read as water.
   always_comb begin
      rd_data   = CELL_WATER;
      disp_data = CELL_WATER;
      if (coord_ok(int'(rd_row), int'(rd_col), BOARD_SIZE)) begin
         rd_data = cells_r[rd_row][rd_col];
      end else begin
         rd_data = CELL_WATER;
      end
      if (coord_ok(int'(disp_row), int'(disp_col), BOARD_SIZE)) begin
         disp_data = cells_r[disp_row][disp_col];
      end else begin
         disp_data = CELL_WATER;
      end
   end

endmodule

// File: rtl/board_engine.sv
// Two-player battleship engine: ship placement, turn-based firing with a fixed
// accept -> resolve -> report pipeline, win detection and a display read port.
module board_engine
   import battle_pkg::*;
#(
   parameter int BOARD_SIZE = 10,
   parameter int HIT_AGAIN  = 1,
   localparam int IDX_W = $clog2(BOARD_SIZE),
   localparam int CNT_W = $clog2(BOARD_SIZE*BOARD_SIZE+1)
) (
   input  logic             clock50,
   input  logic             reset,
   input  logic             place_valid,
   input  logic             place_player,
   input  logic [IDX_W-1:0] place_row,
   input  logic [IDX_W-1:0] place_col,
   output logic             place_ready,
   input  logic             start,
   input  logic             fire_valid,
   input  logic [IDX_W-1:0] fire_row,
   input  logic [IDX_W-1:0] fire_col,
   output logic             fire_ready,
   output logic             result_valid,
   output logic [1:0]       result_code,
   output logic             player_turn,
   output logic             game_over,
   output logic             winner,
   output logic [CNT_W-1:0] ships_left0,
   output logic [CNT_W-1:0] ships_left1,
   input  logic             rd_player,
   input  logic [IDX_W-1:0] rd_row,
   input  logic [IDX_W-1:0] rd_col,
   input  logic             rd_fog,
   output logic [1:0]       rd_cell
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t           state_r, next_state_s;
   logic             turn_r, game_over_r, winner_r, result_valid_r;
   logic [1:0]       result_code_r;
   logic [CNT_W-1:0] ships0_r, ships1_r;
   logic [IDX_W-1:0] shot_row_r, shot_col_r;

   logic             sel_player_s, clear_s, place_ok_s, hit_s, coord_ok_s;
   logic [1:0]       wr_en_s, wr_data_s, res_code_s, cell_s;
   logic [1:0]       int_data0_s, int_data1_s, disp0_s, disp1_s;
   logic [IDX_W-1:0] int_row_s, int_col_s;
   logic [CNT_W-1:0] opp_ships_s;

   // Placement addresses the placing player's board; shots address the opponent's.
   always_comb begin
      sel_player_s = 1'b0;
      int_row_s    = shot_row_r;
      int_col_s    = shot_col_r;
      if (state_r == ST_SETUP) begin
         sel_player_s = place_player;
         int_row_s    = place_row;
         int_col_s    = place_col;
      end else begin
         sel_player_s = ~turn_r;
         int_row_s    = shot_row_r;
         int_col_s    = shot_col_r;
      end
      cell_s      = sel_player_s ? int_data1_s : int_data0_s;
      coord_ok_s  = coord_ok(int'(int_row_s), int'(int_col_s), BOARD_SIZE);
      opp_ships_s = turn_r ? ships0_r : ships1_r;
   end

   // Next-state and board write control.
   always_comb begin
      next_state_s = state_r;
      wr_en_s      = 2'b00;
      wr_data_s    = CELL_WATER;
      clear_s      = 1'b0;
      place_ok_s   = 1'b0;
      hit_s        = 1'b0;
      res_code_s   = RES_REJECT;
      case (state_r)
         ST_SETUP: begin
            if (place_valid && coord_ok_s && (cell_s == CELL_WATER)) begin
               place_ok_s            = 1'b1;
               wr_en_s[sel_player_s] = 1'b1;
               wr_data_s             = CELL_SHIP;
            end else begin
               place_ok_s = 1'b0;
            end
            if (start && !place_valid && (ships0_r != CNT_ZERO) && (ships1_r != CNT_ZERO)) begin
               next_state_s = ST_AIM;
            end else begin
               next_state_s = ST_SETUP;
            end
         end
         ST_AIM: begin
            if (fire_valid) begin
               next_state_s = ST_RESOLVE;
            end else begin
               next_state_s = ST_AIM;
            end
         end
         ST_RESOLVE: begin
            next_state_s = ST_REPORT;
            if (!coord_ok_s) begin
               res_code_s = RES_REJECT;
            end else if (cell_s == CELL_WATER) begin
               res_code_s            = RES_MISS;
               wr_en_s[sel_player_s] = 1'b1;
               wr_data_s             = CELL_MISS;
            end else if (cell_s == CELL_SHIP) begin
               res_code_s            = RES_HIT;
               hit_s                 = 1'b1;
               wr_en_s[sel_player_s] = 1'b1;
               wr_data_s             = CELL_HIT;
            end else begin
               res_code_s = RES_REJECT;
            end
         end
         ST_REPORT: begin
            if (opp_ships_s == CNT_ZERO) begin
               next_state_s = ST_GAME_OVER;
            end else begin
               next_state_s = ST_AIM;
            end
         end
         ST_GAME_OVER: begin
            if (start) begin
               clear_s      = 1'b1;
               next_state_s = ST_SETUP;
            end else begin
               next_state_s = ST_GAME_OVER;
            end
         end
         default: next_state_s = ST_SETUP;
      endcase
   end

   // Game state registers; result_valid is high exactly during REPORT.
   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         state_r        <= ST_SETUP;
         turn_r         <= 1'b0;
         game_over_r    <= 1'b0;
         winner_r       <= 1'b0;
         result_valid_r <= 1'b0;
         result_code_r  <= RES_REJECT;
         ships0_r       <= CNT_ZERO;
         ships1_r       <= CNT_ZERO;
         shot_row_r     <= '0;
         shot_col_r     <= '0;
      end else begin
         state_r        <= next_state_s;
         result_valid_r <= (state_r == ST_RESOLVE);
         case (state_r)
            ST_SETUP: begin
               if (place_ok_s) begin
                  if (place_player) ships1_r <= ships1_r + CNT_ONE;
                  else              ships0_r <= ships0_r + CNT_ONE;
               end
               if (next_state_s == ST_AIM) turn_r <= 1'b0;
            end
            ST_AIM: begin
               if (fire_valid) begin
                  shot_row_r <= fire_row;
                  shot_col_r <= fire_col;
               end
            end
            ST_RESOLVE: begin
               result_code_r <= res_code_s;
               if (hit_s) begin
                  if (turn_r) ships0_r <= ships0_r - CNT_ONE;
                  else        ships1_r <= ships1_r - CNT_ONE;
               end
            end
            ST_REPORT: begin
               if (opp_ships_s == CNT_ZERO) begin
                  game_over_r <= 1'b1;
                  winner_r    <= turn_r;
               end else if (result_code_r == RES_MISS) begin
                  turn_r <= ~turn_r;
               end else if ((result_code_r == RES_HIT) && (HIT_AGAIN == 32'sd0)) begin
                  turn_r <= ~turn_r;
               end
            end
            ST_GAME_OVER: begin
               if (start) begin
                  ships0_r    <= CNT_ZERO;
                  ships1_r    <= CNT_ZERO;
                  game_over_r <= 1'b0;
                  winner_r    <= 1'b0;
                  turn_r      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   board_bank #(.BOARD_SIZE(BOARD_SIZE)) bank0 (
      .clock50   (clock50),
      .reset     (reset),
      .clear     (clear_s),
      .wr_en     (wr_en_s[0]),
      .wr_row    (int_row_s),
      .wr_col    (int_col_s),
      .wr_data   (wr_data_s),
      .rd_row    (int_row_s),
      .rd_col    (int_col_s),
      .rd_data   (int_data0_s),
      .disp_row  (rd_row),
      .disp_col  (rd_col),
      .disp_data (disp0_s)
   );

   board_bank #(.BOARD_SIZE(BOARD_SIZE)) bank1 (
      .clock50   (clock50),
      .reset     (reset),
      .clear     (clear_s),
      .wr_en     (wr_en_s[1]),
      .wr_row    (int_row_s),
      .wr_col    (int_col_s),
      .wr_data   (wr_data_s),
      .rd_row    (int_row_s),
      .rd_col    (int_col_s),
      .rd_data   (int_data1_s),
      .disp_row  (rd_row),
      .disp_col  (rd_col),
      .disp_data (disp1_s)
   );

   // Display view: the fog hides unhit ships from the opponent.
   always_comb begin
      rd_cell = rd_player ? disp1_s : disp0_s;
      if (rd_fog && (rd_cell == CELL_SHIP)) begin
         rd_cell = CELL_WATER;
      end else begin
         rd_cell = rd_cell;
      end
   end

   assign place_ready  = (state_r == ST_SETUP);
   assign fire_ready   = (state_r == ST_AIM);
   assign result_valid = result_valid_r;
   assign result_code  = result_code_r;
   assign player_turn  = turn_r;
   assign game_over    = game_over_r;
   assign winner       = winner_r;
   assign ships_left0  = ships0_r;
   assign ships_left1  = ships1_r;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine: default instance plus a HIT_AGAIN=0 instance
// driven by the same stimulus, checked against hand-computed values.
module tb_board_engine;

   logic       clock50 = 1'b0;
   logic       reset;
   logic       place_valid, place_player, start, fire_valid, rd_player, rd_fog;
   logic [3:0] place_row, place_col, fire_row, fire_col, rd_row, rd_col;

   logic       place_ready, fire_ready, result_valid, player_turn, game_over, winner;
   logic [1:0] result_code, rd_cell;
   logic [6:0] ships_left0, ships_left1;

   logic       b_place_ready, b_fire_ready, b_result_valid, b_player_turn, b_game_over, b_winner;
   logic [1:0] b_result_code, b_rd_cell;
   logic [6:0] b_ships_left0, b_ships_left1;

   int total = 0;
   int bad   = 0;

   always #10 clock50 = ~clock50;

   board_engine dut (
      .clock50(clock50), .reset(reset),
      .place_valid(place_valid), .place_player(place_player), .place_row(place_row),
      .place_col(place_col), .place_ready(place_ready), .start(start),
      .fire_valid(fire_valid), .fire_row(fire_row), .fire_col(fire_col), .fire_ready(fire_ready),
      .result_valid(result_valid), .result_code(result_code), .player_turn(player_turn),
      .game_over(game_over), .winner(winner), .ships_left0(ships_left0), .ships_left1(ships_left1),
      .rd_player(rd_player), .rd_row(rd_row), .rd_col(rd_col), .rd_fog(rd_fog), .rd_cell(rd_cell)
   );

   board_engine #(.BOARD_SIZE(10), .HIT_AGAIN(0)) dut_b (
      .clock50(clock50), .reset(reset),
      .place_valid(place_valid), .place_player(place_player), .place_row(place_row),
      .place_col(place_col), .place_ready(b_place_ready), .start(start),
      .fire_valid(fire_valid), .fire_row(fire_row), .fire_col(fire_col), .fire_ready(b_fire_ready),
      .result_valid(b_result_valid), .result_code(b_result_code), .player_turn(b_player_turn),
      .game_over(b_game_over), .winner(b_winner), .ships_left0(b_ships_left0), .ships_left1(b_ships_left1),
      .rd_player(rd_player), .rd_row(rd_row), .rd_col(rd_col), .rd_fog(rd_fog), .rd_cell(b_rd_cell)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock50);
      #1;
   endtask

   task automatic place(input logic p, input logic [3:0] r, input logic [3:0] c);
      place_valid = 1'b1; place_player = p; place_row = r; place_col = c;
      tick();
      place_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic peek(input logic p, input logic [3:0] r, input logic [3:0] c, input logic fog);
      rd_player = p; rd_row = r; rd_col = c; rd_fog = fog;
      #1;
   endtask

   // Fire one shot and check the fixed accept/resolve/report timing and code.
   task automatic fire(input string tag, input logic [3:0] r, input logic [3:0] c, input logic [1:0] code);
      fire_valid = 1'b1; fire_row = r; fire_col = c;
      tick();
      fire_valid = 1'b0;
      chk({tag, "_rv_acc1"}, 32'(result_valid), 32'd0);
      tick();
      chk({tag, "_rv_acc2"}, 32'(result_valid), 32'd1);
      chk({tag, "_code"}, 32'(result_code), 32'(code));
      tick();
      chk({tag, "_rv_acc3"}, 32'(result_valid), 32'd0);
   endtask

   initial begin
      reset = 1'b1; place_valid = 1'b0; place_player = 1'b0; place_row = 4'd0; place_col = 4'd0;
      start = 1'b0; fire_valid = 1'b0; fire_row = 4'd0; fire_col = 4'd0;
      rd_player = 1'b0; rd_row = 4'd0; rd_col = 4'd0; rd_fog = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_ships0", 32'(ships_left0), 32'd0);
      chk("rst_ships1", 32'(ships_left1), 32'd0);
      chk("rst_turn", 32'(player_turn), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_code", 32'(result_code), 32'd0);
      chk("rst_place_rdy", 32'(place_ready), 32'd1);
      chk("rst_fire_rdy", 32'(fire_ready), 32'd0);

      // Start with no ships is ignored.
      pulse_start();
      chk("early_start", 32'(place_ready), 32'd1);

      place(1'b0, 4'd0, 4'd0);
      place(1'b1, 4'd3, 4'd4);
      place(1'b1, 4'd3, 4'd4);
      place(1'b1, 4'd10, 4'd2);
      chk("setup_ships0", 32'(ships_left0), 32'd1);
      chk("setup_ships1", 32'(ships_left1), 32'd1);
      pulse_start();
      chk("aim_fire_rdy", 32'(fire_ready), 32'd1);
      chk("aim_place_rdy", 32'(place_ready), 32'd0);
      chk("aim_turn", 32'(player_turn), 32'd0);

      // Placement outside SETUP has no effect.
      place(1'b0, 4'd7, 4'd7);
      chk("aim_place_ign", 32'(ships_left0), 32'd1);
      peek(1'b0, 4'd7, 4'd7, 1'b0);
      chk("aim_place_cell", 32'(rd_cell), 32'd0);

      fire("p0_miss", 4'd5, 4'd5, 2'b10);
      peek(1'b1, 4'd5, 4'd5, 1'b0);
      chk("p1_cell_55", 32'(rd_cell), 32'd2);
      chk("turn_after_miss0", 32'(player_turn), 32'd1);

      fire("p1_miss", 4'd5, 4'd5, 2'b10);
      chk("turn_after_miss1", 32'(player_turn), 32'd0);

      fire("p0_repeat", 4'd5, 4'd5, 2'b00);
      chk("turn_after_rej", 32'(player_turn), 32'd0);

      fire("p0_oor", 4'd12, 4'd3, 2'b00);
      chk("turn_after_oor", 32'(player_turn), 32'd0);

      peek(1'b1, 4'd3, 4'd4, 1'b0);
      chk("rd_ship", 32'(rd_cell), 32'd1);
      peek(1'b1, 4'd3, 4'd4, 1'b1);
      chk("rd_fog_ship", 32'(rd_cell), 32'd0);
      peek(1'b1, 4'd12, 4'd3, 1'b0);
      chk("rd_oor", 32'(rd_cell), 32'd0);

      fire("p0_hit", 4'd3, 4'd4, 2'b11);
      chk("win_ships1", 32'(ships_left1), 32'd0);
      chk("win_over", 32'(game_over), 32'd1);
      chk("win_winner", 32'(winner), 32'd0);
      chk("win_fire_rdy", 32'(fire_ready), 32'd0);
      chk("win_over_b", 32'(b_game_over), 32'd1);
      peek(1'b1, 4'd3, 4'd4, 1'b1);
      chk("rd_hit_fog", 32'(rd_cell), 32'd3);

      // Fire after game over is ignored.
      fire_valid = 1'b1; fire_row = 4'd0; fire_col = 4'd0;
      tick();
      fire_valid = 1'b0;
      tick();
      chk("over_fire_rv", 32'(result_valid), 32'd0);
      tick();
      chk("over_fire_rv2", 32'(result_valid), 32'd0);
      peek(1'b1, 4'd0, 4'd0, 1'b0);
      chk("over_fire_cell", 32'(rd_cell), 32'd0);
      chk("over_still", 32'(game_over), 32'd1);

      pulse_start();
      chk("restart_setup", 32'(place_ready), 32'd1);
      chk("restart_over", 32'(game_over), 32'd0);
      chk("restart_ships0", 32'(ships_left0), 32'd0);
      chk("restart_ships1", 32'(ships_left1), 32'd0);
      peek(1'b1, 4'd3, 4'd4, 1'b0);
      chk("restart_cell34", 32'(rd_cell), 32'd0);
      peek(1'b0, 4'd0, 4'd0, 1'b0);
      chk("restart_cell00", 32'(rd_cell), 32'd0);
      peek(1'b1, 4'd5, 4'd5, 1'b0);
      chk("restart_cell55", 32'(rd_cell), 32'd0);

      // Second game: hit with two P1 ships exercises HIT_AGAIN on both instances.
      place(1'b0, 4'd0, 4'd0);
      place(1'b1, 4'd1, 4'd1);
      place(1'b1, 4'd2, 4'd2);
      pulse_start();
      fire("g2_hit", 4'd1, 4'd1, 2'b11);
      chk("g2_b_code", 32'(b_result_code), 32'd3);
      chk("g2_turn_again", 32'(player_turn), 32'd0);
      chk("g2_turn_pass_b", 32'(b_player_turn), 32'd1);
      chk("g2_ships1", 32'(ships_left1), 32'd1);
      chk("g2_ships1_b", 32'(b_ships_left1), 32'd1);
      chk("g2_over", 32'(game_over), 32'd0);

      // Reset pulsed while the shot is in RESOLVE discards it.
      fire_valid = 1'b1; fire_row = 4'd2; fire_col = 4'd2;
      tick();
      fire_valid = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      chk("midrst_rv1", 32'(result_valid), 32'd0);
      tick();
      chk("midrst_rv2", 32'(result_valid), 32'd0);
      chk("midrst_rv_b", 32'(b_result_valid), 32'd0);
      chk("midrst_code", 32'(result_code), 32'd0);
      chk("midrst_ships0", 32'(ships_left0), 32'd0);
      chk("midrst_ships1", 32'(ships_left1), 32'd0);
      chk("midrst_turn_b", 32'(b_player_turn), 32'd0);
      chk("midrst_setup", 32'(place_ready), 32'd1);
      peek(1'b1, 4'd2, 4'd2, 1'b0);
      chk("midrst_cell", 32'(rd_cell), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
